ewb_queue: RTL and testbench

Parametrised multi-entry eviction write buffer between the last-level cache (lower port) and physical memory (higher port). It absorbs dirty-line writebacks into a DEPTH-entry FIFO so the cache can continue without waiting on memory. Buffered lines are drained to memory in the background. Lower-port reads that hit a buffered line are answered locally; a write to an already-buffered address coalesces into that entry.

---
 rtl/ewb_queue_if.sv | 43 ++++
 rtl/ewb_queue.sv | 148 ++++++++++++++
 tb/tb_ewb_queue.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ewb_queue_if.sv
// Cache-side request port, memory-side port and occupancy status of the eviction write buffer.
// The slave modport is the buffer's view; the master modport is the view of whoever drives it.
interface ewb_queue_if #(
    parameter int DEPTH  = 4,
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              ewb_read_i;
    logic              ewb_write_i;
    logic [ADDR_W-1:0] ewb_address_i;
    logic [LINE_W-1:0] ewb_wdata_i;
    logic [LINE_W-1:0] ewb_rdata_o;
    logic              ewb_resp_o;

    logic              mem_read_o;
    logic              mem_write_o;
    logic [ADDR_W-1:0] mem_address_o;
    logic [LINE_W-1:0] mem_wdata_o;
    logic [LINE_W-1:0] mem_rdata_i;
    logic              mem_resp_i;

    logic              full_o;
    logic              empty_o;
    logic [CNT_W-1:0]  count_o;

    modport slave (
        input  ewb_read_i, ewb_write_i, ewb_address_i, ewb_wdata_i,
        output ewb_rdata_o, ewb_resp_o,
        output mem_read_o, mem_write_o, mem_address_o, mem_wdata_o,
        input  mem_rdata_i, mem_resp_i,
        output full_o, empty_o, count_o
    );

    modport master (
        output ewb_read_i, ewb_write_i, ewb_address_i, ewb_wdata_i,
        input  ewb_rdata_o, ewb_resp_o,
        input  mem_read_o, mem_write_o, mem_address_o, mem_wdata_o,
        output mem_rdata_i, mem_resp_i,
        input  full_o, empty_o, count_o
    );
endinterface

// File: rtl/ewb_queue.sv
// Multi-entry eviction write buffer: absorbs dirty-line writebacks into a FIFO, drains them to
// memory in the background, answers read hits locally and coalesces writes to buffered lines.
module ewb_queue #(
    parameter int DEPTH  = 4,
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    ewb_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEM_RD,
        S_MEM_WR
    } state_t;

    state_t            r_state;
    logic [DEPTH-1:0]  r_valid;
    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [LINE_W-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic              r_resp;
    logic [LINE_W-1:0] r_hit_data;

    logic             w_full;
    logic             w_inflight;
    logic             w_pop;
    logic             w_lower_ok;
    logic             w_rd_hit;
    logic [PTR_W-1:0] w_rd_idx;
    logic             w_wr_match;
    logic [PTR_W-1:0] w_wr_idx;
    logic             w_coalesce;
    logic             w_enqueue;
    logic             w_wr_acc;
    logic             w_rd_hit_acc;
    logic             w_rd_miss;
    logic             w_miss_resp;

    assign w_full     = (r_count == CNT_W'(DEPTH));
    assign w_inflight = (r_state == S_MEM_WR);
    assign w_pop      = w_inflight && bus.mem_resp_i;
    // The resp cycle blocks new acceptance so a request still held then is not taken twice.
    assign w_lower_ok = !r_resp && (r_state != S_MEM_RD);

    // Scan oldest to youngest so the last match found is the one closest to the tail.
    always_comb begin
        w_rd_hit   = 1'b0;
        w_rd_idx   = '0;
        w_wr_match = 1'b0;
        w_wr_idx   = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (r_valid[r_head + PTR_W'(k)] &&
                (r_addr[r_head + PTR_W'(k)] == bus.ewb_address_i)) begin
                w_rd_hit = 1'b1;
                w_rd_idx = r_head + PTR_W'(k);
                if (!(w_inflight && (k == 0))) begin
                    w_wr_match = 1'b1;
                    w_wr_idx   = r_head + PTR_W'(k);
                end
            end
        end
    end

    assign w_coalesce   = w_lower_ok && bus.ewb_write_i && w_wr_match;
    assign w_enqueue    = w_lower_ok && bus.ewb_write_i && !w_wr_match && !w_full;
    assign w_wr_acc     = w_coalesce || w_enqueue;
    assign w_rd_hit_acc = w_lower_ok && bus.ewb_read_i && w_rd_hit;
    assign w_rd_miss    = w_lower_ok && bus.ewb_read_i && !w_rd_hit;
    assign w_miss_resp  = (r_state == S_MEM_RD) && bus.mem_resp_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_valid    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_resp     <= 1'b0;
            r_hit_data <= '0;
        end else begin
            r_resp <= w_wr_acc || w_rd_hit_acc;
            if (w_rd_hit_acc) begin
                r_hit_data <= r_data[w_rd_idx];
            end
            if (w_enqueue) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            case ({w_enqueue, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            case (r_state)
                S_IDLE: begin
                    if (w_rd_miss) begin
                        r_state <= S_MEM_RD;
                    end else if (r_count != '0) begin
                        r_state <= S_MEM_WR;
                    end
                end
                S_MEM_RD: begin
                    if (bus.mem_resp_i) begin
                        r_state <= S_IDLE;
                    end
                end
                S_MEM_WR: begin
                    if (bus.mem_resp_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Line storage carries no reset; an entry is meaningful only while its valid bit is set.
    always_ff @(posedge clk) begin
        if (w_enqueue) begin
            r_addr[r_tail] <= bus.ewb_address_i;
            r_data[r_tail] <= bus.ewb_wdata_i;
        end else if (w_coalesce) begin
            r_data[w_wr_idx] <= bus.ewb_wdata_i;
        end
    end

    assign bus.ewb_resp_o    = r_resp || w_miss_resp;
    assign bus.ewb_rdata_o   = w_miss_resp ? bus.mem_rdata_i : (r_resp ? r_hit_data : '0);
    assign bus.mem_read_o    = (r_state == S_MEM_RD);
    assign bus.mem_write_o   = w_inflight;
    assign bus.mem_address_o = (r_state == S_MEM_RD) ? bus.ewb_address_i :
                               (w_inflight ? r_addr[r_head] : '0);
    assign bus.mem_wdata_o   = w_inflight ? r_data[r_head] : '0;
    assign bus.full_o        = w_full;
    assign bus.empty_o       = (r_count == '0);
    assign bus.count_o       = r_count;
endmodule

// File: tb/tb_ewb_queue.sv
// Bench for ewb_queue: directed scenarios with a behavioural memory responder, then random
// traffic checked against a per-line "latest written value" coherence model.
module tb_ewb_queue;
    localparam int DEPTH  = 4;
    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;

    typedef logic [LINE_W-1:0] line_t;
    typedef logic [ADDR_W-1:0] addr_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ewb_queue_if #(.DEPTH(DEPTH), .LINE_W(LINE_W), .ADDR_W(ADDR_W)) bus ();

    ewb_queue #(.DEPTH(DEPTH), .LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_line(input string tag, input line_t obs, input line_t exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural memory: unwritten lines read back as an address-derived pattern.
    logic       mem_stall = 1'b1;
    int         mem_lat   = 1;
    int         mem_cnt;
    line_t      mem_arr [addr_t];
    addr_t      log_a [$];
    line_t      log_d [$];

    function automatic line_t pat(input addr_t a);
        line_t r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = (a * 32'(i + 7)) ^ 32'hC0DE_0000 ^ 32'(i);
        return r;
    endfunction

    function automatic line_t mem_val(input addr_t a);
        return mem_arr.exists(a) ? mem_arr[a] : pat(a);
    endfunction

    function automatic line_t rand_line();
        line_t r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mem_resp_i  = 1'b0;
            bus.mem_rdata_i = '0;
            mem_cnt         = 0;
        end else begin
            #2;
            if (bus.mem_resp_i) begin
                bus.mem_resp_i = 1'b0;
                mem_cnt        = 0;
            end else if ((bus.mem_read_o || bus.mem_write_o) && !mem_stall) begin
                mem_cnt++;
                if (mem_cnt >= mem_lat) begin
                    bus.mem_resp_i = 1'b1;
                    if (bus.mem_write_o) begin
                        log_a.push_back(bus.mem_address_o);
                        log_d.push_back(bus.mem_wdata_o);
                        mem_arr[bus.mem_address_o] = bus.mem_wdata_o;
                    end else begin
                        bus.mem_rdata_i = mem_val(bus.mem_address_o);
                    end
                end
            end
        end
    end

    task automatic do_write(input addr_t a, input line_t d, input int bound, output int lat);
        @(posedge clk); #1;
        bus.ewb_write_i   = 1'b1;
        bus.ewb_address_i = a;
        bus.ewb_wdata_i   = d;
        lat = -1;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clk);
            if (bus.ewb_resp_o) begin
                lat = i;
                break;
            end
        end
        @(posedge clk); #1;
        bus.ewb_write_i = 1'b0;
    endtask

    task automatic do_read(input addr_t a, input int bound, input int release_at,
                           output line_t data, output int lat, output int saw_mrd,
                           output int log_at_mrd);
        @(posedge clk); #1;
        bus.ewb_read_i    = 1'b1;
        bus.ewb_address_i = a;
        data = '0; lat = -1; saw_mrd = 0; log_at_mrd = -1;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clk);
            if (i == release_at) mem_stall = 1'b0;
            if (bus.mem_read_o && (saw_mrd == 0)) begin
                saw_mrd    = 1;
                log_at_mrd = log_a.size();
            end
            if (bus.ewb_resp_o) begin
                lat  = i;
                data = bus.ewb_rdata_o;
                break;
            end
        end
        @(posedge clk); #1;
        bus.ewb_read_i = 1'b0;
    endtask

    task automatic wait_empty(input int bound, output int ok);
        ok = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (bus.empty_o && !bus.mem_write_o && !bus.mem_read_o) begin
                ok = 1;
                break;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed still running, required finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int    lat, ok, base, nresp, seen_pop, saw, lmrd;
        line_t rd;
        line_t dat [5];
        line_t wrap_d [12];
        line_t last_wr [addr_t];
        addr_t a;
        line_t d;

        bus.ewb_read_i    = 1'b0;
        bus.ewb_write_i   = 1'b0;
        bus.ewb_address_i = '0;
        bus.ewb_wdata_i   = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #2;
        chk_int ("rst_resp",  int'(bus.ewb_resp_o), 0);
        chk_int ("rst_mrd",   int'(bus.mem_read_o), 0);
        chk_int ("rst_mwr",   int'(bus.mem_write_o), 0);
        chk_int ("rst_full",  int'(bus.full_o), 0);
        chk_int ("rst_empty", int'(bus.empty_o), 1);
        chk_int ("rst_count", int'(bus.count_o), 0);
        chk_line("rst_rdata", bus.ewb_rdata_o, '0);
        chk_int ("rst_maddr", int'(bus.mem_address_o), 0);
        chk_line("rst_mwdata", bus.mem_wdata_o, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Enqueue to full, then a stalled fifth write released by the first pop
        base = log_a.size();
        mem_stall = 1'b1;
        mem_lat   = 1;
        for (int i = 0; i < 5; i++) dat[i] = rand_line();
        for (int i = 0; i < 4; i++) begin
            do_write(32'(32'h100 * (i + 1)), dat[i], 10, lat);
            chk_int($sformatf("fill_lat_%0d", i), lat, 2);
        end
        chk_int("fill_count", int'(bus.count_o), 4);
        chk_int("fill_full",  int'(bus.full_o), 1);
        chk_int("fill_empty", int'(bus.empty_o), 0);
        @(posedge clk); #1;
        bus.ewb_write_i   = 1'b1;
        bus.ewb_address_i = 32'h500;
        bus.ewb_wdata_i   = dat[4];
        nresp = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.ewb_resp_o) nresp++;
        end
        chk_int("full_noresp", nresp, 0);
        chk_int("full_hold_count", int'(bus.count_o), 4);
        mem_stall = 1'b0;
        seen_pop = -1; lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.mem_resp_i && (seen_pop < 0)) seen_pop = i;
            if (bus.ewb_resp_o) begin
                lat = i;
                break;
            end
        end
        chk_int("full_pop_to_resp", lat - seen_pop, 2);
        @(posedge clk); #1;
        bus.ewb_write_i = 1'b0;
        wait_empty(100, ok);
        chk_int("fill_drained", ok, 1);
        chk_int("fill_log_len", log_a.size() - base, 5);
        for (int i = 0; i < 5; i++) begin
            if (base + i < log_a.size()) begin
                chk_int ($sformatf("fill_order_addr_%0d", i), int'(log_a[base+i]), 32'h100 * (i + 1));
                chk_line($sformatf("fill_order_data_%0d", i), log_d[base+i], dat[i]);
            end
        end

        // Coalesce behind a stalled head
        base = log_a.size();
        mem_stall = 1'b1;
        dat[0] = rand_line(); dat[1] = rand_line(); dat[2] = rand_line();
        do_write(32'h600, dat[0], 10, lat);
        do_write(32'h200, dat[1], 10, lat);
        do_write(32'h200, dat[2], 10, lat);
        chk_int("coal_lat", lat, 2);
        chk_int("coal_count", int'(bus.count_o), 2);
        do_read(32'h200, 10, -1, rd, lat, saw, lmrd);
        chk_line("coal_read", rd, dat[2]);
        mem_stall = 1'b0;
        wait_empty(100, ok);
        chk_int("coal_drained", ok, 1);
        chk_int("coal_log_len", log_a.size() - base, 2);
        if (log_a.size() >= base + 2) begin
            chk_int ("coal_addr0", int'(log_a[base]), 32'h600);
            chk_int ("coal_addr1", int'(log_a[base+1]), 32'h200);
            chk_line("coal_data1", log_d[base+1], dat[2]);
        end

        // Read hit served locally, read miss waits for the in-flight drain
        base = log_a.size();
        mem_stall = 1'b1;
        dat[0] = rand_line();
        do_write(32'h300, dat[0], 10, lat);
        do_read(32'h300, 10, -1, rd, lat, saw, lmrd);
        chk_line("hit_data", rd, dat[0]);
        chk_int ("hit_lat", lat, 2);
        chk_int ("hit_no_mrd", saw, 0);
        mem_lat = 2;
        do_read(32'h700, 40, 4, rd, lat, saw, lmrd);
        chk_int ("miss_mrd", saw, 1);
        chk_int ("miss_after_drain", lmrd - base, 1);
        chk_line("miss_data", rd, pat(32'h700));
        wait_empty(50, ok);
        chk_int("miss_empty", ok, 1);

        // Write to the in-flight head allocates a new entry
        base = log_a.size();
        mem_stall = 1'b1;
        mem_lat   = 1;
        dat[0] = rand_line(); dat[1] = rand_line();
        do_write(32'h100, dat[0], 10, lat);
        do_write(32'h100, dat[1], 10, lat);
        chk_int("ovl_lat", lat, 2);
        chk_int("ovl_count", int'(bus.count_o), 2);
        do_read(32'h100, 10, -1, rd, lat, saw, lmrd);
        chk_line("ovl_read", rd, dat[1]);
        mem_stall = 1'b0;
        wait_empty(100, ok);
        chk_int("ovl_log_len", log_a.size() - base, 2);
        if (log_a.size() >= base + 2) begin
            chk_line("ovl_first",  log_d[base],   dat[0]);
            chk_line("ovl_second", log_d[base+1], dat[1]);
        end

        // Asynchronous reset in the middle of a drain
        base = log_a.size();
        mem_stall = 1'b1;
        do_write(32'h800, rand_line(), 10, lat);
        @(negedge clk);
        chk_int("arst_pre_mwr", int'(bus.mem_write_o), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_int("arst_mwr",   int'(bus.mem_write_o), 0);
        chk_int("arst_count", int'(bus.count_o), 0);
        chk_int("arst_empty", int'(bus.empty_o), 1);
        @(negedge clk);
        rst_n     = 1'b1;
        mem_stall = 1'b0;
        do_read(32'h800, 20, -1, rd, lat, saw, lmrd);
        chk_int ("arst_read_mem", saw, 1);
        chk_line("arst_read_data", rd, pat(32'h800));
        chk_int ("arst_dropped", log_a.size() - base, 0);

        // Wrap-around: 3*DEPTH writes interleaved with slow drains
        base = log_a.size();
        mem_lat = 3;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            wrap_d[i] = rand_line();
            do_write(32'h2000 + 32'(i * 32'h20), wrap_d[i], 50, lat);
            chk_int($sformatf("wrap_bound_%0d", i), int'(int'(bus.count_o) <= DEPTH), 1);
        end
        wait_empty(200, ok);
        chk_int("wrap_drained", ok, 1);
        chk_int("wrap_log_len", log_a.size() - base, 3 * DEPTH);
        for (int i = 0; i < 3 * DEPTH; i++) begin
            if (base + i < log_a.size()) begin
                chk_int ($sformatf("wrap_addr_%0d", i), int'(log_a[base+i]), 32'h2000 + i * 32'h20);
                chk_line($sformatf("wrap_data_%0d", i), log_d[base+i], wrap_d[i]);
            end
        end

        // Random traffic: every read must return the latest value written to that line
        for (int n = 0; n < 80; n++) begin
            mem_lat = int'($urandom_range(1, 3));
            a = 32'h3000 + 32'($urandom_range(0, 7)) * 32'h20;
            if ($urandom_range(0, 9) < 6) begin
                d = rand_line();
                do_write(a, d, 60, lat);
                chk_int($sformatf("rnd_wr_acc_%0d", n), int'(lat > 0), 1);
                last_wr[a] = d;
            end else begin
                do_read(a, 60, -1, rd, lat, saw, lmrd);
                chk_line($sformatf("rnd_rd_%0d_%0h", n, a), rd,
                         last_wr.exists(a) ? last_wr[a] : pat(a));
            end
            chk_int($sformatf("rnd_bound_%0d", n), int'(int'(bus.count_o) <= DEPTH), 1);
        end
        wait_empty(300, ok);
        chk_int("rnd_drained", ok, 1);
        for (int k = 0; k < 8; k++) begin
            a = 32'h3000 + 32'(k) * 32'h20;
            if (last_wr.exists(a)) chk_line($sformatf("rnd_mem_%0h", a), mem_val(a), last_wr[a]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
